simd_satalu_pipe: RTL and testbench

Parametrised, two-stage pipelined SIMD ALU. It is the successor to the combinational 16-bit add/AND/NOT/saturating-add components. A `DATA_W = LANES*LANE_W` operand word is split into independent signed lanes, and each lane performs wrap add, saturating add, saturating subtract or bitwise AND. The block sits between the register-read stage and writeback, with valid/ready handshakes on both sides and per-lane overflow reporting.

---
 rtl/simd_satalu_pipe_pkg.sv | 20 ++
 rtl/simd_satalu_pipe_if.sv | 29 ++
 rtl/simd_satalu_pipe_lane.sv | 49 ++++
 rtl/simd_satalu_pipe.sv | 109 ++++++++++
 tb/tb_simd_satalu_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/simd_satalu_pipe_pkg.sv
// Shared op encodings and saturation helper for the SIMD saturating ALU.
package simd_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SATADD = 2'b01,
        OP_SATSUB = 2'b10,
        OP_AND    = 2'b11
    } op_e;

    localparam int SAT_MAX_W = 64;

    // neg=1 gives the most negative w-bit value, neg=0 the most positive.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic neg, input int unsigned w);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (w - 1);
        return neg ? msb : (msb - SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/simd_satalu_pipe_if.sv
// Operand/result handshake bundle for simd_satalu_pipe. The DUT uses the slave
// modport (consumes operands, produces results); the master drives it.
interface simd_satalu_pipe_if #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
);
    localparam int DATA_W = LANE_W * LANES;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LANES-1:0]  out_ovf;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/simd_satalu_pipe_lane.sv
// One SIMD lane: S1 add/sub with signed-overflow detect, and the S2 result
// select working off the registered S1 values held in the top level.
module simd_satalu_lane
    import simd_alu_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  op_e               i_op,
    output logic [LANE_W-1:0] o_raw,
    output logic              o_ovf,
    output logic              o_amsb,
    input  logic [LANE_W-1:0] i_s1_raw,
    input  logic              i_s1_ovf,
    input  logic              i_s1_amsb,
    input  op_e               i_s1_op,
    output logic [LANE_W-1:0] o_res
);

    logic [LANE_W:0]   w_sum;
    logic [LANE_W-1:0] w_bop;
    logic [LANE_W-1:0] w_sat;
    logic              w_sub;

    assign w_sat = LANE_W'(sat_value(i_s1_amsb, LANE_W));

    always_comb begin
        w_sub  = (i_op == OP_SATSUB);
        w_bop  = w_sub ? ~i_b : i_b;
        w_sum  = {1'b0, i_a} + {1'b0, w_bop} + {{LANE_W{1'b0}}, w_sub};
        o_amsb = i_a[LANE_W-1];
        o_raw  = w_sum[LANE_W-1:0];
        // signed overflow <=> carry into the sign bit differs from carry out
        o_ovf  = w_sum[LANE_W] ^ w_sum[LANE_W-1] ^ i_a[LANE_W-1] ^ w_bop[LANE_W-1];
        if (i_op == OP_AND) begin
            o_raw = i_a & i_b;
            o_ovf = 1'b0;
        end
    end

    always_comb begin
        o_res = i_s1_raw;
        if ((i_s1_op == OP_SATADD || i_s1_op == OP_SATSUB) && i_s1_ovf) begin
            o_res = w_sat;
        end
    end

endmodule

// File: rtl/simd_satalu_pipe.sv
// Two-stage pipelined SIMD ALU (wrap add, sat add, sat sub, AND) with
// valid/ready on both sides. Define SIMD_SATALU_STICKY_EN for sticky overflow flags.
module simd_satalu_pipe
    import simd_alu_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 2
) (
    input logic               clk,
    input logic               rst_n,
    simd_satalu_pipe_if.slave bus
`ifdef SIMD_SATALU_STICKY_EN
    ,
    input  logic              ovf_clr,
    output logic [LANES-1:0]  ovf_sticky
`endif
);

    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

    lanes_t           w_a, w_b, w_raw, w_res;
    lanes_t           r_s1_raw, r_out_data;
    logic [LANES-1:0] w_ovf, w_amsb;
    logic [LANES-1:0] r_s1_ovf, r_s1_amsb, r_out_ovf;
    op_e              w_op, r_s1_op;
    logic             r_s1_valid, r_out_valid;
    logic             w_s2_en, w_s1_ld;

    assign w_a  = bus.in_a;
    assign w_b  = bus.in_b;
    assign w_op = op_e'(bus.in_op);

    // in_ready depends only on pipeline state and out_ready, never on in_valid
    assign w_s2_en      = !r_out_valid || bus.out_ready;
    assign w_s1_ld      = !r_s1_valid || w_s2_en;
    assign bus.in_ready = w_s1_ld;

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            simd_satalu_lane #(.LANE_W(LANE_W)) u_lane (
                .i_a       (w_a[gi]),
                .i_b       (w_b[gi]),
                .i_op      (w_op),
                .o_raw     (w_raw[gi]),
                .o_ovf     (w_ovf[gi]),
                .o_amsb    (w_amsb[gi]),
                .i_s1_raw  (r_s1_raw[gi]),
                .i_s1_ovf  (r_s1_ovf[gi]),
                .i_s1_amsb (r_s1_amsb[gi]),
                .i_s1_op   (r_s1_op),
                .o_res     (w_res[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_ovf   <= '0;
            r_s1_amsb  <= '0;
            r_s1_op    <= OP_ADD;
        end else if (w_s1_ld) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_raw  <= w_raw;
                r_s1_ovf  <= w_ovf;
                r_s1_amsb <= w_amsb;
                r_s1_op   <= w_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res;
                r_out_ovf  <= r_s1_ovf;
            end
        end
    end

`ifdef SIMD_SATALU_STICKY_EN
    logic             w_xfer;
    logic [LANES-1:0] r_sticky;

    assign w_xfer     = r_out_valid && bus.out_ready;
    assign ovf_sticky = r_sticky;

    // a flag transferred in the same cycle as a clear still lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (ovf_clr ? '0 : r_sticky) | (w_xfer ? r_out_ovf : '0);
        end
    end
`endif

endmodule

// File: tb/tb_simd_satalu_pipe.sv
// Self-checking bench for simd_satalu_pipe: vector table, handshake corner
// sequences and a randomized run against a lane-arithmetic scoreboard.
module tb_simd_satalu_pipe;
    import simd_alu_pkg::*;

    localparam int LW   = 8;
    localparam int NL   = 2;
    localparam int DW   = LW * NL;
    localparam int MAXV = (1 << (LW - 1)) - 1;
    localparam int MINV = -(1 << (LW - 1));

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic [NL-1:0] o;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [NL-1:0] o;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];

    simd_satalu_pipe_if #(.LANE_W(LW), .LANES(NL)) bus();

`ifdef SIMD_SATALU_STICKY_EN
    logic          ovf_clr;
    logic [NL-1:0] ovf_sticky;
`endif

    simd_satalu_pipe #(.LANE_W(LW), .LANES(NL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef SIMD_SATALU_STICKY_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: per-lane signed integer arithmetic, clamped to the lane range.
    function automatic res_t model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        res_t r;
        int   sa, sb, s;
        r.d = '0;
        r.o = '0;
        for (int i = 0; i < NL; i++) begin
            sa = int'($signed(a[i*LW +: LW]));
            sb = int'($signed(b[i*LW +: LW]));
            s  = (op == 2'b10) ? sa - sb : sa + sb;
            if (op == 2'b11) begin
                r.d[i*LW +: LW] = a[i*LW +: LW] & b[i*LW +: LW];
            end else begin
                r.o[i] = (s > MAXV) || (s < MINV);
                if (op == 2'b00 || !r.o[i]) r.d[i*LW +: LW] = s[LW-1:0];
                else r.d[i*LW +: LW] = (s > MAXV) ? LW'(MAXV) : LW'(MINV);
            end
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
    endtask

    // Called at a negedge after inputs are set; scores this cycle, advances one clock.
    task automatic step();
        res_t r;
        #1;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_spurious: got out_data=%0h want no output", bus.out_data);
            end else begin
                r = exp_q[0];
                chk("sb_data", 32'(bus.out_data), 32'(r.d));
                chk("sb_ovf", 32'(bus.out_ovf), 32'(r.o));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want TB_RESULT");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{OP_SATADD, 16'h7F10, 16'h0105, 16'h7F15, 2'b10};
        tbl[1] = '{OP_SATADD, 16'h8080, 16'hFF80, 16'h8080, 2'b11};
        tbl[2] = '{OP_ADD,    16'h7F10, 16'h0105, 16'h8015, 2'b10};
        tbl[3] = '{OP_SATSUB, 16'h8000, 16'h0101, 16'h80FF, 2'b10};
        tbl[4] = '{OP_AND,    16'hF0F0, 16'h3C3C, 16'h3030, 2'b00};
        tbl[5] = '{OP_SATSUB, 16'h7F00, 16'h8001, 16'h7FFF, 2'b10};
        tbl[6] = '{OP_ADD,    16'h0102, 16'h0304, 16'h0406, 2'b00};

        drive(1'b0, 2'b00, '0, '0, 1'b0);
`ifdef SIMD_SATALU_STICKY_EN
        ovf_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SIMD_SATALU_STICKY_EN
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Directed vectors, one at a time, including the 2-cycle latency
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("tbl%0d_lat_valid", i), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_ovf", i), 32'(bus.out_ovf), 32'(tbl[i].o));
        end
        @(negedge clk);
        chk("tbl_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: two fill the pipe, third waits, then all drain in order
        drive(1'b1, OP_ADD, 16'h1122, 16'h0101, 1'b0);
        #1 chk("bp_ready_a", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b1, OP_SATSUB, 16'h8000, 16'h0101, 1'b0);
        #1 chk("bp_ready_b", 32'(bus.in_ready), 32'd1);
        step();
        drive(1'b1, OP_AND, 16'hF0F0, 16'h3C3C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_ready_rise", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_second_out", 32'(bus.out_data), 32'h80FF);
        step();
        chk("bp_third_out", 32'(bus.out_data), 32'h3030);
        for (int k = 0; k < 6 && exp_q.size() > 0; k++) step();
        chk("bp_all_out", 32'(exp_q.size()), 32'd0);

        // Reset with two results in flight
        drive(1'b1, OP_ADD, 16'h0102, 16'h0304, 1'b0);
        step();
        drive(1'b1, OP_AND, 16'hFFFF, 16'h1234, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end

`ifdef SIMD_SATALU_STICKY_EN
        chk("sticky_after_rst", 32'(ovf_sticky), 32'd0);
        drive(1'b1, OP_SATADD, 16'h7F10, 16'h0105, 1'b1);
        step();
        drive(1'b1, OP_SATADD, 16'h0010, 16'h007F, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("sticky_both", 32'(ovf_sticky), 32'd3);
        drive(1'b1, OP_SATADD, 16'h0010, 16'h007F, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4 && !bus.out_valid; k++) step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sticky_clr_set_wins", 32'(ovf_sticky), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("sticky_clr", 32'(ovf_sticky), 32'd0);
`endif

        // Randomized traffic with random backpressure
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), DW'($urandom),
                  DW'($urandom), $urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 2'b00, '0, '0, 1'b1);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
